// File: rtl/mac_accum_param.sv
// mac_accum_param: pairs operand A and operand B from two independent valid
// streams, multiplies each pair (signed or unsigned per pair) and sums DEPTH
// products into one ACC_W-bit result, flagged by a one-cycle out_valid pulse.
//
// Pipeline:
//   holding FSM  -> picks up A and B, which may arrive in different cycles
//   stage 1      -> registered product, valid bit, last-of-block flag, mode
//   stage 2      -> accumulator; publishes mac_out on the last product
//
// Handshake: in_valid_a / in_valid_b are plain valid strobes with no ready;
// every valid operand is consumed (paired, held, or overwriting the held copy
// of the same operand). out_valid is a single-cycle pulse and mac_out holds
// until the next result.
//
// Optional feature: define MAC_ACCUM_SAT_EN to clamp every accumulation to
// the ACC_W range of the product's mode and report clamps on sat_flag.
// Without the macro the accumulator wraps and sat_flag is tied to 0.
//
// Parameter constraints: DATA_W >= 2, DEPTH >= 2, ACC_W >= 2*DATA_W,
// 2**CNT_W >= DEPTH.

module mac_accum_param #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int ACC_W  = 11,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_a,
   input  logic              in_valid_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_valid_b,
   input  logic              is_signed,
   input  logic              clear,
   output logic [ACC_W-1:0]  mac_out,
   output logic              out_valid,
   output logic [CNT_W-1:0]  pair_cnt,
   output logic              sat_flag
);

   localparam int              PROD_W   = 2 * DATA_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   // Operand holding state; state_q is the observation point for this FSM.
   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_HAVE_A = 2'd1,
      S_HAVE_B = 2'd2
   } hold_state_e;

   hold_state_e       state_q, state_d;
   logic [DATA_W-1:0] hold_a_q, hold_a_d;
   logic [DATA_W-1:0] hold_b_q, hold_b_d;

   // Pairing and product
   logic              avail_a, avail_b, accept;
   logic [DATA_W-1:0] op_a, op_b;
   logic [PROD_W-1:0] ext_a, ext_b, prod;

   // Stage 1 registers
   logic              p_valid_q, p_valid_d;
   logic [PROD_W-1:0] p_data_q, p_data_d;
   logic              p_last_q, p_last_d;
   logic              p_signed_q, p_signed_d;
   logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;

   // Stage 2 registers
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  mac_out_q, mac_out_d;
   logic              out_valid_q, out_valid_d;
   logic [ACC_W-1:0]  sum_acc;

   // An operand is available when held or presented live; live wins.
   always_comb begin
      avail_a = in_valid_a || (state_q == S_HAVE_A);
      avail_b = in_valid_b || (state_q == S_HAVE_B);
      accept  = avail_a && avail_b && !clear;
      op_a    = in_valid_a ? in_a : hold_a_q;
      op_b    = in_valid_b ? in_b : hold_b_q;
   end

   // Holding FSM next state: pair, capture a lone operand, or keep waiting.
   always_comb begin
      state_d  = state_q;
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      if (clear) begin
         state_d  = S_EMPTY;
         hold_a_d = '0;
         hold_b_d = '0;
      end else if (accept) begin
         state_d = S_EMPTY;
      end else if (in_valid_a) begin
         // EMPTY or HAVE_A with no B: take (or overwrite) the held A.
         state_d  = S_HAVE_A;
         hold_a_d = in_a;
      end else if (in_valid_b) begin
         state_d  = S_HAVE_B;
         hold_b_d = in_b;
      end
   end

   // Full-width product; signed mode sign-extends both operands first so a
   // plain PROD_W-bit multiply yields the two's-complement product.
   always_comb begin
      if (is_signed) begin
         ext_a = {{DATA_W{op_a[DATA_W-1]}}, op_a};
         ext_b = {{DATA_W{op_b[DATA_W-1]}}, op_b};
      end else begin
         ext_a = {{DATA_W{1'b0}}, op_a};
         ext_b = {{DATA_W{1'b0}}, op_b};
      end
      prod = ext_a * ext_b;
   end

   // Stage 1: latch the product with its block position and mode.
   always_comb begin
      p_valid_d  = accept;
      p_data_d   = p_data_q;
      p_last_d   = p_last_q;
      p_signed_d = p_signed_q;
      pair_cnt_d = pair_cnt_q;
      if (clear) begin
         pair_cnt_d = '0;
      end else if (accept) begin
         p_data_d   = prod;
         p_last_d   = (pair_cnt_q == LAST_CNT);
         p_signed_d = is_signed;
         pair_cnt_d = (pair_cnt_q == LAST_CNT) ? '0 : pair_cnt_q + CNT_W'(1);
      end
   end

`ifdef MAC_ACCUM_SAT_EN
   // Two guard bits hold any single-step overflow in either mode.
   localparam int SUM_W = ACC_W + 2;

   logic [SUM_W-1:0] acc_ext, prod_ext, sum_w;
   logic             clamp;
   logic             sticky_q, sticky_d;
   logic             sat_flag_q, sat_flag_d;

   // Saturating add: clamp to the signed or unsigned ACC_W range of this product.
   always_comb begin
      if (p_signed_q) begin
         acc_ext  = SUM_W'($signed(acc_q));
         prod_ext = SUM_W'($signed(p_data_q));
      end else begin
         acc_ext  = SUM_W'(acc_q);
         prod_ext = SUM_W'(p_data_q);
      end
      sum_w   = acc_ext + prod_ext;
      sum_acc = sum_w[ACC_W-1:0];
      clamp   = 1'b0;
      if (p_signed_q) begin
         // In range only when every bit above the ACC_W sign bit matches it.
         if (sum_w[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){sum_w[SUM_W-1]}}) begin
            clamp   = 1'b1;
            sum_acc = sum_w[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (sum_w[SUM_W-1:ACC_W] != '0) begin
         clamp   = 1'b1;
         sum_acc = '1;
      end
   end

   // Sticky clamp record for the block, published alongside mac_out.
   always_comb begin
      sticky_d   = sticky_q;
      sat_flag_d = sat_flag_q;
      if (clear) begin
         sticky_d = 1'b0;
      end else if (p_valid_q) begin
         if (p_last_q) begin
            sat_flag_d = sticky_q | clamp;
            sticky_d   = 1'b0;
         end else begin
            sticky_d = sticky_q | clamp;
         end
      end
   end

   // Saturation status registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sticky_q   <= 1'b0;
         sat_flag_q <= 1'b0;
      end else begin
         sticky_q   <= sticky_d;
         sat_flag_q <= sat_flag_d;
      end
   end

   assign sat_flag = sat_flag_q;
`else
   logic [ACC_W-1:0] prod_acc;

   // Wrapping add modulo 2**ACC_W with the product extended per its mode.
   always_comb begin
      if (p_signed_q) begin
         prod_acc = ACC_W'($signed(p_data_q));
      end else begin
         prod_acc = ACC_W'(p_data_q);
      end
      sum_acc = acc_q + prod_acc;
   end

   assign sat_flag = 1'b0;
`endif

   // Stage 2: accumulate; the last product of a block publishes and restarts.
   always_comb begin
      acc_d       = acc_q;
      mac_out_d   = mac_out_q;
      out_valid_d = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (p_valid_q) begin
         if (p_last_q) begin
            mac_out_d   = sum_acc;
            out_valid_d = 1'b1;
            acc_d       = '0;
         end else begin
            acc_d = sum_acc;
         end
      end
   end

   // All datapath and FSM registers; reset outranks clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_EMPTY;
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         p_valid_q   <= 1'b0;
         p_data_q    <= '0;
         p_last_q    <= 1'b0;
         p_signed_q  <= 1'b0;
         pair_cnt_q  <= '0;
         acc_q       <= '0;
         mac_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         p_valid_q   <= p_valid_d;
         p_data_q    <= p_data_d;
         p_last_q    <= p_last_d;
         p_signed_q  <= p_signed_d;
         pair_cnt_q  <= pair_cnt_d;
         acc_q       <= acc_d;
         mac_out_q   <= mac_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign mac_out   = mac_out_q;
   assign out_valid = out_valid_q;
   assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_mac_accum_param.sv
// tb_mac_accum_param: drives two instances of mac_accum_param (default
// ACC_W=11 and a narrow ACC_W=8 copy) from the same operand streams and
// compares both against a block-level reference model. Build with
// MAC_ACCUM_SAT_EN defined to exercise the saturating variant.

module tb_mac_accum_param;

   localparam int DEPTH = 8;
   localparam int EW    = 53;  // {cycle[31:0], mac11[10:0], sat11, mac8[7:0], sat8}
`ifdef MAC_ACCUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        reset_n, clear, is_signed;
   logic        in_valid_a, in_valid_b;
   logic [3:0]  in_a, in_b;
   logic [10:0] mac_out;
   logic        out_valid, sat_flag;
   logic [2:0]  pair_cnt;
   logic [7:0]  mac_out8;
   logic        out_valid8, sat_flag8;
   logic [2:0]  pair_cnt8;

   mac_accum_param #(.DATA_W(4), .DEPTH(DEPTH), .ACC_W(11), .CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_valid_a(in_valid_a),
      .in_b(in_b), .in_valid_b(in_valid_b), .is_signed(is_signed), .clear(clear),
      .mac_out(mac_out), .out_valid(out_valid), .pair_cnt(pair_cnt), .sat_flag(sat_flag)
   );

   mac_accum_param #(.DATA_W(4), .DEPTH(DEPTH), .ACC_W(8), .CNT_W(3)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_a(in_a), .in_valid_a(in_valid_a),
      .in_b(in_b), .in_valid_b(in_valid_b), .is_signed(is_signed), .clear(clear),
      .mac_out(mac_out8), .out_valid(out_valid8), .pair_cnt(pair_cnt8), .sat_flag(sat_flag8)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int edge_cnt = 0;
   bit rst_at_edge = 1'b0;
   always @(posedge clk) begin
      edge_cnt    <= edge_cnt + 1;
      rst_at_edge <= !reset_n;
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp_v, edge_cnt);
      end
   endfunction

   // ---------------- reference model ----------------
   bit     m_have_a = 0, m_have_b = 0;
   int     m_ha = 0, m_hb = 0;
   int     m_cnt = 0;
   longint m_acc11 = 0, m_acc8 = 0;
   bit     m_st11 = 0, m_st8 = 0;

   function automatic longint op_val(input int raw, input bit sgn);
      return (sgn && raw >= 8) ? longint'(raw - 16) : longint'(raw);
   endfunction

   // One accumulation into an accw-bit register holding raw bits 0..2**accw-1.
   function automatic longint acc_step(input longint acc, input longint p, input bit sgn,
                                       input int accw, output bit clamped);
      longint m;
      longint s;
      m = longint'(1) << accw;
      clamped = 1'b0;
      if (SAT && sgn) begin
         s = ((acc >= m / 2) ? acc - m : acc) + p;
         if (s > m / 2 - 1) begin s = m / 2 - 1; clamped = 1'b1; end
         else if (s < -(m / 2)) begin s = -(m / 2); clamped = 1'b1; end
      end else if (SAT) begin
         s = acc + p;
         if (s > m - 1) begin s = m - 1; clamped = 1'b1; end
      end else begin
         s = acc + p;
      end
      return ((s % m) + m) % m;
   endfunction

   // Applies the inputs sampled at edge e; a completed block is due at e+1.
   task automatic model_step(input bit r, input bit c, input bit va, input int a,
                             input bit vb, input int b, input bit sgn, input int e);
      bit            c11, c8;
      int            oa, ob;
      longint        p;
      logic [EW-1:0] ent;
      logic [31:0]   due;
      if (!r || c) begin
         if (exp_q.size() > 0) begin
            ent = exp_q[exp_q.size() - 1];
            due = ent[EW-1:EW-32];
            if (int'(due) == e) void'(exp_q.pop_back());
         end
         m_have_a = 0; m_have_b = 0; m_cnt = 0;
         m_acc11 = 0; m_acc8 = 0; m_st11 = 0; m_st8 = 0;
         if (!r) begin m_ha = 0; m_hb = 0; end
      end else if ((va || m_have_a) && (vb || m_have_b)) begin
         oa = va ? a : m_ha;
         ob = vb ? b : m_hb;
         p  = op_val(oa, sgn) * op_val(ob, sgn);
         m_acc11 = acc_step(m_acc11, p, sgn, 11, c11);
         m_acc8  = acc_step(m_acc8,  p, sgn, 8,  c8);
         m_st11  = m_st11 | c11;
         m_st8   = m_st8  | c8;
         m_have_a = 0; m_have_b = 0;
         m_cnt++;
         if (m_cnt == DEPTH) begin
            ent = {32'(e + 1), m_acc11[10:0], m_st11, m_acc8[7:0], m_st8};
            exp_q.push_back(ent);
            m_cnt = 0; m_acc11 = 0; m_acc8 = 0; m_st11 = 0; m_st8 = 0;
         end
      end else if (va) begin
         m_have_a = 1; m_have_b = 0; m_ha = a;
      end else if (vb) begin
         m_have_b = 1; m_have_a = 0; m_hb = b;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input bit r, input bit c, input bit va, input int a,
                      input bit vb, input int b, input bit sgn);
      reset_n    = r;
      clear      = c;
      in_valid_a = va;
      in_a       = 4'(a);
      in_valid_b = vb;
      in_b       = 4'(b);
      is_signed  = sgn;
      @(posedge clk);
      #1;
      model_step(r, c, va, a & 15, vb, b & 15, sgn, edge_cnt);
   endtask

   task automatic pair(input int a, input int b, input bit sgn);
      cyc(1, 0, 1, a, 1, b, sgn);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_clear();
      cyc(1, 1, 0, 0, 0, 0, 0);
   endtask

   // ---------------- monitor ----------------
   logic [10:0] hold11 = '0;
   logic [7:0]  hold8  = '0;
   logic        hs11 = 1'b0, hs8 = 1'b0;

   always @(negedge clk) begin
      logic [EW-1:0] ent;
      logic [31:0]   due_cyc;
      bit            due;
      if (mon_en) begin
         chk("pair_cnt", pair_cnt, m_cnt);
         chk("pair_cnt8", pair_cnt8, m_cnt);
         if (rst_at_edge) begin
            hold11 = '0; hold8 = '0; hs11 = 1'b0; hs8 = 1'b0;
         end
         due = 1'b0;
         if (exp_q.size() > 0) begin
            ent     = exp_q[0];
            due_cyc = ent[EW-1:EW-32];
            due     = (int'(due_cyc) <= edge_cnt);
         end
         if (out_valid || out_valid8 || due) begin
            if (exp_q.size() == 0) begin
               chk("spurious out_valid", {out_valid, out_valid8}, 2'b00);
            end else begin
               ent = exp_q.pop_front();
               chk("out_valid both", {out_valid, out_valid8}, 2'b11);
               chk("result cycle", edge_cnt, ent[EW-1:EW-32]);
               chk("mac_out", mac_out, ent[20:10]);
               chk("sat_flag", sat_flag, ent[9]);
               chk("mac_out8", mac_out8, ent[8:1]);
               chk("sat_flag8", sat_flag8, ent[0]);
               hold11 = ent[20:10]; hs11 = ent[9];
               hold8  = ent[8:1];   hs8  = ent[0];
            end
         end else begin
            chk("outputs hold", {mac_out, sat_flag, mac_out8, sat_flag8},
                {hold11, hs11, hold8, hs8});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0; clear = 1'b0; is_signed = 1'b0;
      in_valid_a = 1'b0; in_valid_b = 1'b0; in_a = '0; in_b = '0;

      cyc(0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      cyc(0, 0, 1, 5, 1, 5, 0);
      chk("reset mac_out", mac_out, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset pair_cnt", pair_cnt, 0);
      chk("reset sat_flag", sat_flag, 0);

      // Signed 3 * -2 eight times -> -48
      do_clear();
      for (int i = 0; i < 8; i++) pair(3, -2, 1);
      idle(3);
      chk("signed block", mac_out, 11'h7D0);
      chk("pair_cnt after block", pair_cnt, 0);

      // Split arrival, then last-wins overwrite, then six 1*1 -> 20+14+6
      do_clear();
      cyc(1, 0, 1, 5, 0, 0, 0);
      idle(1);
      cyc(1, 0, 0, 0, 1, 4, 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 7, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 2, 0);
      for (int i = 0; i < 6; i++) pair(1, 1, 0);
      idle(3);
      chk("split and overwrite", mac_out, 40);

      // B held first, then A arrives with a fresh B (live B wins)
      do_clear();
      cyc(1, 0, 0, 0, 1, 9, 0);
      cyc(1, 0, 1, 3, 1, 2, 0);
      cyc(1, 0, 1, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) pair(1, 1, 0);
      idle(3);
      chk("live beats held", mac_out, 13);

      // Back-to-back blocks: 8 then 32, spacing checked via expected cycles
      do_clear();
      for (int i = 0; i < 8; i++) pair(1, 1, 0);
      for (int i = 0; i < 8; i++) pair(2, 2, 0);
      idle(3);
      chk("back-to-back second", mac_out, 32);

      // Unsigned vs signed interpretation of 15
      do_clear();
      for (int i = 0; i < 8; i++) pair(15, 15, 0);
      idle(3);
      chk("unsigned 15*15", mac_out, 1800);
      for (int i = 0; i < 8; i++) pair(15, 15, 1);
      idle(3);
      chk("signed -1*-1", mac_out, 8);

      // Clear mid-block restarts the count
      do_clear();
      for (int i = 0; i < 5; i++) pair(1, 1, 0);
      do_clear();
      for (int i = 0; i < 8; i++) pair(1, 1, 0);
      idle(3);
      chk("after clear", mac_out, 8);

      // Reset mid-block zeroes everything; next block is intact
      for (int i = 0; i < 3; i++) pair(2, 3, 0);
      cyc(0, 0, 1, 2, 1, 3, 0);
      chk("mid reset mac_out", mac_out, 0);
      chk("mid reset pair_cnt", pair_cnt, 0);
      for (int i = 0; i < 8; i++) pair(1, 1, 0);
      idle(3);
      chk("after reset", mac_out, 8);

      // Clear right after the last pair drops that result; clear beats valids
      for (int i = 0; i < 8; i++) pair(3, 3, 0);
      cyc(1, 1, 1, 4, 1, 4, 0);
      idle(3);
      chk("dropped result keeps mac_out", mac_out, 8);

      // Narrow accumulator: 8 * 64 saturates to 127 or wraps to 0
      do_clear();
      for (int i = 0; i < 8; i++) pair(-8, -8, 1);
      idle(3);
      chk("acc8 sat/wrap", mac_out8, SAT ? 127 : 0);
      chk("acc8 sat_flag", sat_flag8, SAT ? 1 : 0);
      chk("acc11 no clamp", mac_out, 512);

      // Randomised operand streams, modes, clears and resets
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
      end
      idle(5);
      chk("expected queue drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
